// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Round-robin share of the register-file write port between the ALU
//            and the multi-cycle unit, plus a pending-write hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================

module regfile_write_arbiter #(
   parameter int NREQ = 2
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        wb0_valid,
   input  logic [4:0]  wb0_reg,
   input  logic [31:0] wb0_data,
   output logic        wb0_ready,

   input  logic        wb1_valid,
   input  logic [4:0]  wb1_reg,
   input  logic [31:0] wb1_data,
   output logic        wb1_ready,

   input  logic        reserve_en,
   input  logic [4:0]  reserve_reg,
   input  logic [4:0]  chk_reg1,
   input  logic [4:0]  chk_reg2,
   output logic        hazard1,
   output logic        hazard2,

   output logic        RegWrite,
   output logic [4:0]  WriteReg,
   output logic [31:0] WriteData
);

   localparam int                c_RR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int                c_NREGS   = 32;
   localparam logic [c_NREGS-1:0] c_R0_MASK = c_NREGS'(1);

   logic [c_RR_W-1:0]  r_rr;
   logic               r_regwrite;
   logic [4:0]         r_writereg;
   logic [31:0]        r_writedata;
   logic [c_NREGS-1:0] r_pending;

   logic               w_grant0;
   logic               w_grant1;
   logic               w_grant;
   logic [4:0]         w_gnt_reg;
   logic [31:0]        w_gnt_data;
   logic [c_NREGS-1:0] w_set;
   logic [c_NREGS-1:0] w_clr;

   // Grant depends only on the valids and the pointer, never on reg/data.
   assign w_grant0   = wb0_valid & (~wb1_valid | (r_rr == c_RR_W'(0)));
   assign w_grant1   = wb1_valid & ~w_grant0;
   assign w_grant    = w_grant0 | w_grant1;
   assign w_gnt_reg  = w_grant1 ? wb1_reg  : wb0_reg;
   assign w_gnt_data = w_grant1 ? wb1_data : wb0_data;

   assign wb0_ready  = w_grant0;
   assign wb1_ready  = w_grant1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr        <= '0;
         r_regwrite  <= 1'b0;
         r_writereg  <= '0;
         r_writedata <= '0;
      end else begin
         r_regwrite <= w_grant & (w_gnt_reg != 5'd0);
         if (w_grant) begin
            r_rr        <= w_grant0 ? c_RR_W'(1) : c_RR_W'(0);
            r_writereg  <= w_gnt_reg;
            r_writedata <= w_gnt_data;
         end
      end
   end

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (reserve_en) begin
         w_set[reserve_reg] = 1'b1;
      end
      if (r_regwrite) begin
         w_clr[r_writereg] = 1'b1;
      end
   end

   // Set is applied after clear so a re-reservation of the register being
   // retired keeps it pending; r0 is masked off and never reports a hazard.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= ((r_pending & ~w_clr) | w_set) & ~c_R0_MASK;
      end
   end

   assign hazard1   = r_pending[chk_reg1];
   assign hazard2   = r_pending[chk_reg2];

   assign RegWrite  = r_regwrite;
   assign WriteReg  = r_writereg;
   assign WriteData = r_writedata;

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the register file's single write port (RegWrite/WriteReg/WriteData) between two writeback producers:
  - requester 0: ALU writeback.
  - requester 1: multi-cycle load/multiply unit.
- Also keeps a 32-entry pending-write scoreboard that the decode stage uses to detect read-after-write hazards.
- Sits between the writeback producers and the register file; its outputs drive the register file write port directly.

## Interface
- NREQ, 2, number of requesters (fixed at 2; round-robin logic is written for 2)
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- wb0_valid  input  1  requester 0 has a write pending
- wb0_reg  input  5  requester 0 destination register
- wb0_data  input  32  requester 0 write data
- wb0_ready  output  1  requester 0 accepted this cycle (combinational)
- wb1_valid, wb1_reg, wb1_data, wb1_ready: same as above, for requester 1
- reserve_en  input  1  decode issues an instruction with a destination
- reserve_reg  input  5  destination being reserved
- chk_reg1  input  5  decode source register A
- chk_reg2  input  5  decode source register B
- hazard1  output  1  chk_reg1 has a pending write (combinational)
- hazard2  output  1  chk_reg2 has a pending write (combinational)
- RegWrite  output  1  register file write enable (registered)
- WriteReg  output  5  register file write address (registered)
- WriteData  output  32  register file write data (registered)

## Operation
**Arbitration**
- Round-robin pointer `rr`, 1 bit; rr=0 means requester 0 wins a tie.
- Only one valid requester: it is granted.
- Both valid: grant requester `rr`.
- After any grant, rr is set to the index of the requester not granted.
- wbN_ready = grant to N. A transfer occurs when valid && ready in the same cycle.
- A requester must hold valid/reg/data stable until ready. Data sampled while not ready is ignored.
- The arbiter never stalls: every cycle with at least one valid requester produces exactly one grant.

**Output register**, on each rising edge:
- If a grant occurred, load WriteReg/WriteData from the granted requester.
- RegWrite <= grant && (granted reg != 0).
- A write to r0 is still accepted (ready=1) but produces RegWrite=0.
- If there is no grant, RegWrite <= 0; WriteReg/WriteData hold their values.

**Scoreboard** `pending[31:0]`
- Set: reserve_en && reserve_reg != 0 sets pending[reserve_reg] at the edge. reserve_reg = 0 is ignored.
- Clear: RegWrite high clears pending[WriteReg] at the edge ending that cycle.
- Simultaneous set and clear of the same index: set wins, because a new producer is in flight.
- pending[0] is constant 0.
- hazardK = pending[chk_regK]. Therefore chk_regK = 0 gives 0.

**Reset**
- rst_n low at an edge sets: RegWrite=0, WriteReg=0, WriteData=0, rr=0, pending=0.
- wb*_ready are combinational and follow their inputs during reset. A transfer accepted in a reset cycle is dropped.
- Reset asserted mid-operation discards any in-flight write (RegWrite=0 the next cycle) and clears all hazards.

## Timing
- Grant in cycle N:
  - RegWrite/WriteReg/WriteData valid in cycle N+1.
  - Register file updated at the edge ending N+1.
- A read of that register in cycle N+2 returns the new value.
- Scoreboard timing for register r:
  - pending[r] stays high through cycle N+1 (hazard is conservative).
  - pending[r] is low from N+2.
- Reserve in cycle M: hazard visible from cycle M+1.
- Throughput: one write per cycle sustained.
- With both requesters always valid, grants strictly alternate 0,1,0,1…
- ready is purely combinational from wb*_valid and rr, with no path from the data inputs.

## Test plan
- **Reset:** drive rst_n=0 for 2 cycles with both requesters valid. Required: RegWrite=0, WriteReg=0, WriteData=0, hazard1=hazard2=0. After release, the first tie grants requester 0.
- **Single requester:** wb0 writes r8=0x0000_1234 in cycle N. Required: wb0_ready=1 in N; RegWrite=1, WriteReg=8, WriteData=0x1234 in N+1; RegWrite=0 in N+2.
- **Contention:** both valid for 4 cycles (wb0 r9=0xA, wb1 r10=0xB, each source re-presenting after acceptance). Required: grants 0,1,0,1; WriteReg sequence 9,10,9,10.
- **r0 write:** wb1 writes r0=0xFFFF_FFFF. Required: wb1_ready=1, RegWrite stays 0, no scoreboard change.
- **Scoreboard:**
  - Reserve r12 in cycle M. Required: hazard1=1 with chk_reg1=12 from M+1.
  - wb0 writes r12 in cycle N. Required: hazard1 still 1 in N+1, 0 in N+2.
  - Reserve r12 again in the same cycle RegWrite writes r12. Required: hazard stays 1.
- **Reset mid-operation:** grant r13 in N, assert rst_n=0 in N+1. Required: RegWrite=0 in N+2 and all pending cleared.
